m_pipe_reg: RTL and testbench

Execute-to-memory pipeline register of the ysyx_23060251 core. It is the receiving end of the execute unit's valid/ready output handshake: it accepts `e_valid_i` and drives back the ready the execute unit sees as `M_ready_i`. It holds the execute result bundle and presents it to the memory stage (LSU) through a second valid/ready handshake. An optional skid entry registers the ready path so that ready timing does not propagate from the LSU back into the execute stage.

---
 rtl/m_pipe_reg.sv | 95 +++++++++
 tb/tb_m_pipe_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/m_pipe_reg.sv
// Execute-to-memory pipeline register with valid/ready on both sides.
// Define YSYX_23060251_M_PIPE_SKID_EN to add a skid entry and register m_ready_o.
module m_pipe_reg #(
  parameter int OPINFO_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                e_valid_i,
  output logic                m_ready_o,
  input  logic [31:0]         pc_i,
  input  logic [31:0]         res_i,
  input  logic [31:0]         src2_i,
  input  logic [4:0]          rd_i,
  input  logic                rd_wen_i,
  input  logic [OPINFO_W-1:0] opinfo_i,
  input  logic                flush_i,
  output logic                M_valid_o,
  input  logic                lsu_ready_i,
  output logic [31:0]         pc_o,
  output logic [31:0]         res_o,
  output logic [31:0]         src2_o,
  output logic [4:0]          rd_o,
  output logic                rd_wen_o,
  output logic [OPINFO_W-1:0] opinfo_o
);

  // Handshakes: a bundle transfers on a side only in a cycle where both its
  // valid and its ready are high; valid never waits on ready.
  localparam int BW = 102 + OPINFO_W;

  logic [BW-1:0] in_b;
  logic [BW-1:0] main_b;
  logic          main_v;
  logic          accept;
  logic          consume;

  assign in_b    = {pc_i, res_i, src2_i, rd_i, rd_wen_i, opinfo_i};
  assign {pc_o, res_o, src2_o, rd_o, rd_wen_o, opinfo_o} = main_b;
  assign M_valid_o = main_v;
  assign accept    = e_valid_i & m_ready_o;
  assign consume   = main_v & lsu_ready_i;

`ifdef YSYX_23060251_M_PIPE_SKID_EN
  logic [BW-1:0] skid_b;
  logic          skid_free;

  // Ready is the inverse of skid occupancy, kept directly as a flop so no
  // LSU timing reaches the execute stage.
  assign m_ready_o = skid_free;

  always_ff @(posedge clock) begin
    if (reset) begin
      main_v    <= 1'b0;
      skid_free <= 1'b1;
      main_b    <= '0;
      skid_b    <= '0;
    end else if (flush_i) begin
      main_v    <= 1'b0;
      skid_free <= 1'b1;
    end else if (!skid_free) begin
      if (consume) begin
        main_b    <= skid_b;
        skid_free <= 1'b1;
      end
    end else if (accept) begin
      if (!main_v || consume) begin
        main_b <= in_b;
        main_v <= 1'b1;
      end else begin
        skid_b    <= in_b;
        skid_free <= 1'b0;
      end
    end else if (consume) begin
      main_v <= 1'b0;
    end
  end
`else
  assign m_ready_o = ~main_v | lsu_ready_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      main_v <= 1'b0;
      main_b <= '0;
    end else if (flush_i) begin
      main_v <= 1'b0;
    end else if (accept) begin
      main_b <= in_b;
      main_v <= 1'b1;
    end else if (consume) begin
      main_v <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_m_pipe_reg.sv
// Randomized bench for m_pipe_reg: a FIFO-of-accepted-bundles model checked
// by a negedge monitor against every output handshake.
module tb_m_pipe_reg;

  localparam int OPINFO_W = 16;
  localparam int BW = 102 + OPINFO_W;

  logic                clock;
  logic                reset;
  logic                e_valid_i;
  logic                m_ready_o;
  logic [31:0]         pc_i;
  logic [31:0]         res_i;
  logic [31:0]         src2_i;
  logic [4:0]          rd_i;
  logic                rd_wen_i;
  logic [OPINFO_W-1:0] opinfo_i;
  logic                flush_i;
  logic                M_valid_o;
  logic                lsu_ready_i;
  logic [31:0]         pc_o;
  logic [31:0]         res_o;
  logic [31:0]         src2_o;
  logic [4:0]          rd_o;
  logic                rd_wen_o;
  logic [OPINFO_W-1:0] opinfo_o;

  logic [BW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic          mon_en = 1'b0;

  m_pipe_reg #(.OPINFO_W(OPINFO_W)) dut (
    .clock(clock), .reset(reset), .e_valid_i(e_valid_i), .m_ready_o(m_ready_o),
    .pc_i(pc_i), .res_i(res_i), .src2_i(src2_i), .rd_i(rd_i), .rd_wen_i(rd_wen_i),
    .opinfo_i(opinfo_i), .flush_i(flush_i), .M_valid_o(M_valid_o),
    .lsu_ready_i(lsu_ready_i), .pc_o(pc_o), .res_o(res_o), .src2_o(src2_o),
    .rd_o(rd_o), .rd_wen_o(rd_wen_o), .opinfo_o(opinfo_o)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected ready derived from how many accepted bundles are still in flight.
  function automatic logic exp_ready(input int occ, input logic lr);
`ifdef YSYX_23060251_M_PIPE_SKID_EN
    return occ < 2;
`else
    return (occ == 0) || lr;
`endif
  endfunction

  // monitor
  always @(negedge clock) begin
    if (mon_en) begin
      chk("m_valid", M_valid_o, exp_q.size() != 0);
      chk("m_ready", m_ready_o, exp_ready(exp_q.size(), lsu_ready_i));
      if (M_valid_o && lsu_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL bundle_extra: got pc %0h expected no bundle", pc_o);
        end else begin
          chk("bundle", {pc_o, res_o, src2_o, rd_o, rd_wen_o, opinfo_o}, exp_q.pop_front());
        end
      end
    end
  end

  // driver: one cycle of stimulus; the model is updated after the monitor
  // has consumed this cycle's output handshake.
  task automatic drive(input logic ev, input logic [31:0] pc, input logic lr,
                       input logic fl, input logic rs);
    e_valid_i   = ev;
    pc_i        = pc;
    res_i       = $urandom;
    src2_i      = $urandom;
    rd_i        = 5'($urandom_range(0, 31));
    rd_wen_i    = 1'($urandom_range(0, 1));
    opinfo_i    = OPINFO_W'($urandom);
    lsu_ready_i = lr;
    flush_i     = fl;
    reset       = rs;
    @(negedge clock);
    #2;
    if (rs || fl) exp_q.delete();
    else if (ev && m_ready_o)
      exp_q.push_back({pc_i, res_i, src2_i, rd_i, rd_wen_i, opinfo_i});
    @(posedge clock);
    #1;
  endtask

  initial begin
    drive(0, 32'h0, 0, 0, 1);
    drive(0, 32'h0, 0, 0, 1);
    chk("rst_m_valid", M_valid_o, 1'b0);
    chk("rst_m_ready", m_ready_o, 1'b1);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_res", res_o, 32'h0);
    chk("rst_rd", {rd_o, rd_wen_o}, 6'h0);
    mon_en = 1'b1;

    // streaming: one bundle per cycle, each visible the next cycle
    for (int n = 0; n < 8; n++) begin
      drive(1, 32'h8000_0000 + 32'(4 * n), 1, 0, 0);
      chk("stream_pc", pc_o, 32'h8000_0000 + 32'(4 * n));
      chk("stream_valid", M_valid_o, 1'b1);
    end
    for (int n = 0; n < 3; n++) drive(0, 32'h0, 1, 0, 0);

    // stall
    drive(1, 32'h8000_0000, 1, 0, 0);
    drive(1, 32'h8000_0004, 0, 0, 0);
    chk("stall_pc", pc_o, 32'h8000_0000);
    drive(0, 32'h0, 0, 0, 0);
    chk("stall_hold_pc", pc_o, 32'h8000_0000);
    for (int n = 0; n < 3; n++) drive(1, 32'h8000_0004, 1, 0, 0);
    for (int n = 0; n < 3; n++) drive(0, 32'h0, 1, 0, 0);

    // flush with entries full and a same-cycle offer
    drive(1, 32'h8000_0008, 0, 0, 0);
    drive(1, 32'h8000_000c, 0, 0, 0);
    drive(1, 32'h8000_0010, 0, 1, 0);
    chk("flush_valid", M_valid_o, 1'b0);
    chk("flush_ready", m_ready_o, 1'b1);
    drive(0, 32'h0, 1, 0, 0);

    // reset mid-stall
    drive(1, 32'h8000_0020, 0, 0, 0);
    drive(1, 32'h8000_0024, 0, 0, 0);
    drive(1, 32'h8000_0028, 0, 0, 1);
    chk("rst_mid_valid", M_valid_o, 1'b0);
    drive(1, 32'h8000_0100, 0, 0, 0);
    chk("rst_mid_first", pc_o, 32'h8000_0100);
    drive(0, 32'h0, 1, 0, 0);

    // non-skid same-cycle replace: consume and accept together
    drive(1, 32'h8000_0200, 0, 0, 0);
    drive(1, 32'h8000_0204, 1, 0, 0);
    chk("replace_pc", pc_o, 32'h8000_0204);
    chk("replace_valid", M_valid_o, 1'b1);

    // random traffic
    for (int n = 0; n < 600; n++)
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2);

    for (int n = 0; n < 4; n++) drive(0, 32'h0, 1, 0, 0);
    chk("drain_empty", 32'(exp_q.size()), 32'h0);
    chk("drain_valid", M_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
